instruction_cache: RTL

- Direct-mapped, read-only instruction cache; the responder to the PC register.
- Takes the PC as ADDRESS and returns INSTRUCTION.
- Raises BUSYWAIT on a miss, which stalls the PC and the IF/ID stage.
- Refills one whole block from instruction memory through a busywait-style handshake.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/instruction_cache_if.sv | 33 +++
 rtl/icache_line_store.sv | 42 ++++
 rtl/instruction_cache.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared constants, state encoding and word-select helper for the
// direct-mapped instruction cache.
package cache_pkg;

    localparam int ADDR_BITS       = 32;
    localparam int INDEX_BITS      = 3;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int OFFSET_BITS     = 2;
    localparam int BYTE_BITS       = 2;
    localparam int TAG_BITS        = ADDR_BITS - INDEX_BITS - OFFSET_BITS - BYTE_BITS;
    localparam int LINES           = 1 << INDEX_BITS;
    localparam int BLOCK_BITS      = 32 * WORDS_PER_BLOCK;
    localparam int MEM_ADDR_BITS   = ADDR_BITS - OFFSET_BITS - BYTE_BITS;

    // PC reset value; the cache treats it as "no fetch this cycle".
    localparam logic [ADDR_BITS-1:0] IDLE_ADDRESS = 32'hFFFFFFFC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    function automatic logic [31:0] select_word(input logic [BLOCK_BITS-1:0] block,
                                                input logic [OFFSET_BITS-1:0] offset);
        return block[{offset, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// CPU-side fetch port and memory-side refill port of the instruction cache.
// slave is the cache; master is whoever drives ADDRESS and answers refills.
interface instruction_cache_if;

    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic [27:0]  MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    modport slave (
        input  ADDRESS,
        output INSTRUCTION,
        output BUSYWAIT,
        output MEM_ADDRESS,
        output MEM_READ,
        input  MEM_READDATA,
        input  MEM_BUSYWAIT
    );

    modport master (
        output ADDRESS,
        input  INSTRUCTION,
        input  BUSYWAIT,
        input  MEM_ADDRESS,
        input  MEM_READ,
        output MEM_READDATA,
        output MEM_BUSYWAIT
    );

endinterface

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the cache lines: combinational read by index,
// synchronous write, synchronous clear of the valid bits on RESET.
module icache_line_store
    import cache_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    output logic                  o_rd_valid,
    output logic [TAG_BITS-1:0]   o_rd_tag,
    output logic [BLOCK_BITS-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [BLOCK_BITS-1:0] i_wr_data
);

    logic [LINES-1:0]      r_valid;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [BLOCK_BITS-1:0] r_data [LINES];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    // Tags and data are left alone on reset; the cleared valid bit hides them.
    always_ff @(posedge CLK) begin
        if (!RESET && i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_index];
    assign o_rd_tag   = r_tag[i_rd_index];
    assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, whole-block
// refill from instruction memory on a miss, BUSYWAIT stalls the fetch stage.
//
// state    | meaning
// IDLE     | lookup ADDRESS; hit or idle address answers, miss starts refill
// MEM_READ | MEM_READ high, wait for MEM_BUSYWAIT low, capture block
// UPDATE   | write captured block, tag and valid into the line
module instruction_cache
    import cache_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    instruction_cache_if.slave  bus
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [MEM_ADDR_BITS-1:0] r_mem_address;
    logic [BLOCK_BITS-1:0]    r_block;

    logic [ADDR_BITS-1:0]     w_address;
    logic [TAG_BITS-1:0]      w_tag;
    logic [INDEX_BITS-1:0]    w_index;
    logic [OFFSET_BITS-1:0]   w_offset;
    logic                     w_idle_req;

    logic                     w_rd_valid;
    logic [TAG_BITS-1:0]      w_rd_tag;
    logic [BLOCK_BITS-1:0]    w_rd_data;
    logic                     w_hit;
    logic                     w_miss;

    logic                     w_wr_en;
    logic [INDEX_BITS-1:0]    w_wr_index;
    logic [TAG_BITS-1:0]      w_wr_tag;

    logic                     w_busywait;
    logic                     w_mem_read;
    logic [31:0]              w_instruction;

    assign w_address  = bus.ADDRESS;
    assign w_tag      = w_address[ADDR_BITS-1 -: TAG_BITS];
    assign w_index    = w_address[BYTE_BITS+OFFSET_BITS +: INDEX_BITS];
    assign w_offset   = w_address[BYTE_BITS +: OFFSET_BITS];
    assign w_idle_req = (w_address == IDLE_ADDRESS);

    assign w_hit  = w_rd_valid && (w_rd_tag == w_tag);
    assign w_miss = (r_state == IDLE) && !w_idle_req && !w_hit;

    // The latched block address already carries the index and tag of the refill,
    // so a stray ADDRESS change mid-refill cannot redirect the install.
    assign w_wr_en    = (r_state == UPDATE);
    assign w_wr_index = r_mem_address[INDEX_BITS-1:0];
    assign w_wr_tag   = r_mem_address[MEM_ADDR_BITS-1 -: TAG_BITS];

    icache_line_store u_line_store (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_rd_index (w_index),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_index (w_wr_index),
        .i_wr_tag   (w_wr_tag),
        .i_wr_data  (r_block)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mem_address <= '0;
            r_block       <= '0;
        end else begin
            if (w_miss) begin
                r_mem_address <= w_address[ADDR_BITS-1 -: MEM_ADDR_BITS];
            end
            if (r_state == MEM_READ && !bus.MEM_BUSYWAIT) begin
                r_block <= bus.MEM_READDATA;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_busywait    = 1'b0;
        w_mem_read    = 1'b0;
        w_instruction = '0;
        case (r_state)
            IDLE: begin
                if (!w_idle_req) begin
                    if (w_hit) begin
                        w_instruction = select_word(w_rd_data, w_offset);
                    end else begin
                        w_busywait   = 1'b1;
                        w_state_next = MEM_READ;
                    end
                end
            end
            MEM_READ: begin
                w_busywait = 1'b1;
                w_mem_read = 1'b1;
                if (!bus.MEM_BUSYWAIT) begin
                    w_state_next = UPDATE;
                end
            end
            UPDATE: begin
                w_busywait   = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.INSTRUCTION = w_instruction;
    assign bus.BUSYWAIT    = w_busywait;
    assign bus.MEM_READ    = w_mem_read;
    assign bus.MEM_ADDRESS = r_mem_address;

endmodule
